sample_framer: RTL and testbench
================================

SAMPLE_FRAMER -- requirements
Module: sample_framer

Interface
REQ-001 SHALL provide parameter N, default 16: samples per frame; matches the FFT processor input count.
REQ-002 SHALL provide parameter ADC_W, default 12: width of the unsigned ADC input sample.
REQ-003 SHALL provide parameter W, default 16: width of each signed output sample.
REQ-004 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port in_data  input  ADC_W  unsigned ADC sample.
REQ-007 SHALL have port in_valid  input  1  in_data is valid this cycle.
REQ-008 SHALL have port in_ready  output  1  block accepts a sample this cycle; a transfer occurs when in_valid and in_ready are both high.
REQ-009 SHALL have port frame_data  output  N*W  N signed samples; sample 0 (oldest) in bits W-1:0.
REQ-010 SHALL have port frame_valid  output  1  frame_data holds a complete frame.
REQ-011 SHALL have port frame_ready  input  1  consumer takes the frame when frame_valid and frame_ready are both high.
REQ-012 SHALL have port frame_count  output  8  number of frames delivered, modulo 256.

Function
REQ-013 SHALL convert each accepted sample to signed form: (in_data - 2^(ADC_W-1)), sign-extended, then shifted left by W-ADC_W; for the defaults, 0x000->0x8000, 0x800->0x0000, 0xFFF->0x7FF0.
REQ-014 SHALL use two banks of N samples (ping-pong): one write bank filled by a write pointer 0..N-1, and one read bank driving frame_data.
REQ-015 SHALL implement the FSM states FILL (read bank empty), PEND (read bank full, write bank filling) and STALL (both banks full).
REQ-016 In FILL, when the Nth sample is accepted, the banks SHALL swap, the pointer SHALL reset to 0, and the state SHALL go to PEND; frame_valid SHALL be 1 on the following cycle (1-cycle latency).
REQ-017 In PEND, a frame handshake with no bank completion SHALL go to FILL and drop frame_valid on the next cycle.
REQ-018 In PEND, completion of the Nth sample with no frame handshake SHALL go to STALL.
REQ-019 In PEND, a frame handshake and Nth-sample completion in the same cycle SHALL swap the banks, remain in PEND, and keep frame_valid at 1 with the new frame on the next cycle.
REQ-020 In STALL, in_ready SHALL be 0; a frame handshake SHALL swap the banks, go to PEND, and raise in_ready on the next cycle; no sample is ever dropped.
REQ-021 in_ready SHALL be registered-equivalent: it depends only on state, never combinationally on in_valid or frame_ready.
REQ-022 frame_data SHALL stay stable while frame_valid is high and not yet accepted.
REQ-023 frame_count SHALL increment by 1 on each frame handshake and wrap from 255 to 0.
REQ-024 Sample order within a frame SHALL be acceptance order; the write pointer SHALL wrap from N-1 to 0.

Reset
REQ-025 While rst is high (asynchronous): state=FILL, write pointer=0, bank select=0, frame_valid=0, in_ready=0, frame_count=0; bank contents are don't-care.
REQ-026 in_ready SHALL rise on the first clock edge after rst deasserts.
REQ-027 A reset mid-frame SHALL discard any partial or pending frame; the first frame after reset consists of the next N accepted samples.

Structure
REQ-028 The constants N, W and ADC_W and the FSM state enum SHALL live in a shared package, audio_pkg, used by this block and the FFT processor.
REQ-029 The block SHALL contain one sub-module, sample_bank: N x W register storage with a write port and a flattened read bus; it is instantiated twice.
REQ-030 The ADC conversion SHALL be inline combinational logic feeding the bank write port.

Verification
REQ-031 Reset, then feed 16 samples 0x000..0xF00 (step 0x100) with frame_ready=1 -> frame_valid high 1 cycle after the 16th sample; frame_data sample 0 = 0x8000 and sample 15 = 0x7000; frame_count = 1.
REQ-032 frame_ready=0, feed 32 samples continuously -> state reaches STALL and in_ready goes 0 after the 32nd sample; the first frame is held stable; after one frame_ready pulse, in_ready=1 on the next cycle and the second frame is presented.
REQ-033 In PEND, assert frame_ready in the same cycle the 16th sample of the next frame is accepted -> frame_valid stays 1 and frame_data switches to the new frame on the next cycle, with no gap.
REQ-034 Assert rst asynchronously after 9 samples -> frame_valid=0 and in_ready=0 immediately; the next 16 samples form a clean frame with no residue.
REQ-035 Deliver 257 frames -> frame_count wraps to 1; random in_valid and frame_ready gaps cause no lost or duplicated samples (scoreboard check).

Source files
------------

// File: rtl/audio_pkg.sv
// Shared audio-path constants and the framer FSM state encoding.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package audio_pkg;

  // Samples per frame; equals the FFT processor input count.
  localparam int AUDIO_N     = 16;
  // Unsigned ADC sample width.
  localparam int AUDIO_ADC_W = 12;
  // Signed sample width used downstream of the framer.
  localparam int AUDIO_W     = 16;

  // FILL: read bank empty; PEND: read bank full, write bank filling;
  // STALL: both banks full, input held off.
  typedef enum logic [1:0] {
    FILL  = 2'd0,
    PEND  = 2'd1,
    STALL = 2'd2
  } framer_state_t;

endpackage

// File: rtl/sample_framer_if.sv
// Sample-in / frame-out handshake bundle for the sample framer.
// Latency: n/a (wiring only).
// Backpressure: in_ready throttles the ADC side, frame_ready throttles the frame side.
interface sample_framer_if #(
  parameter int N     = audio_pkg::AUDIO_N,
  parameter int ADC_W = audio_pkg::AUDIO_ADC_W,
  parameter int W     = audio_pkg::AUDIO_W
) ();

  logic [ADC_W-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic [N*W-1:0]   frame_data;
  logic             frame_valid;
  logic             frame_ready;
  logic [7:0]       frame_count;

  // Environment side: produces samples, consumes frames.
  modport master (
    output in_data, in_valid, frame_ready,
    input  in_ready, frame_data, frame_valid, frame_count
  );

  // Framer side: consumes samples, produces frames.
  modport slave (
    input  in_data, in_valid, frame_ready,
    output in_ready, frame_data, frame_valid, frame_count
  );

endinterface

// File: rtl/sample_bank.sv
// N x W sample register bank with one write port and a flattened read bus.
// Latency: write visible on o_rdata the cycle after i_we.
// Backpressure: none; the owner gates i_we.
module sample_bank #(
  parameter int N  = audio_pkg::AUDIO_N,
  parameter int W  = audio_pkg::AUDIO_W,
  parameter int AW = (N > 1) ? $clog2(N) : 1
) (
  input  logic           clk,
  input  logic           i_we,
  input  logic [AW-1:0]  i_waddr,
  input  logic [W-1:0]   i_wdata,
  output logic [N*W-1:0] o_rdata
);

  logic [W-1:0] r_mem [N];

  // Sample storage; contents are don't-care after reset, so no reset here.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  for (genvar g = 0; g < N; g++) begin : g_rd
    assign o_rdata[g*W +: W] = r_mem[g];
  end

endmodule

// File: rtl/sample_framer.sv
// Packs N converted ADC samples into ping-pong frames for the FFT processor.
// Latency: frame_valid rises 1 cycle after the Nth sample is accepted.
// Backpressure: in_ready drops (registered) only when both banks hold full frames.
module sample_framer #(
  parameter int N     = audio_pkg::AUDIO_N,
  parameter int ADC_W = audio_pkg::AUDIO_ADC_W,
  parameter int W     = audio_pkg::AUDIO_W
) (
  input  logic           clk,
  input  logic           rst,
  sample_framer_if.slave bus
);

  import audio_pkg::*;

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  framer_state_t   r_state;
  framer_state_t   w_state_nxt;
  logic [PW-1:0]   r_wptr;
  logic            r_bsel;        // bank currently being written
  logic            r_in_ready;
  logic            r_frame_valid;
  logic [7:0]      r_count;

  logic            w_in_xfer;
  logic            w_out_xfer;
  logic            w_last;
  logic            w_swap;
  logic [ADC_W-1:0] w_off;
  logic [W-1:0]    w_samp;
  logic [N*W-1:0]  w_bank0_rd;
  logic [N*W-1:0]  w_bank1_rd;

  assign w_in_xfer  = bus.in_valid & r_in_ready;
  assign w_out_xfer = r_frame_valid & bus.frame_ready;
  assign w_last     = w_in_xfer && (r_wptr == PW'(N - 1));

  // Offset-binary to two's complement is an MSB flip; then sign-extend and left-justify.
  assign w_off  = {~bus.in_data[ADC_W-1], bus.in_data[ADC_W-2:0]};
  assign w_samp = W'($signed(w_off)) << (W - ADC_W);

  // Next-state and bank-swap decision from the two handshakes.
  always_comb begin
    w_state_nxt = r_state;
    w_swap      = 1'b0;
    case (r_state)
      FILL: begin
        if (w_last) begin
          w_state_nxt = PEND;
          w_swap      = 1'b1;
        end
      end
      PEND: begin
        if (w_out_xfer && w_last) begin
          w_swap = 1'b1;
        end else if (w_out_xfer) begin
          w_state_nxt = FILL;
        end else if (w_last) begin
          w_state_nxt = STALL;
        end
      end
      STALL: begin
        if (w_out_xfer) begin
          w_state_nxt = PEND;
          w_swap      = 1'b1;
        end
      end
      default: begin
        w_state_nxt = FILL;
      end
    endcase
  end

  // State, bank select and the registered handshake outputs derived from next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= FILL;
      r_bsel        <= 1'b0;
      r_in_ready    <= 1'b0;
      r_frame_valid <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_bsel        <= r_bsel ^ w_swap;
      r_in_ready    <= (w_state_nxt != STALL);
      r_frame_valid <= (w_state_nxt != FILL);
    end
  end

  // Write pointer walks 0..N-1 in acceptance order and wraps on the last sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr <= '0;
    end else if (w_in_xfer) begin
      r_wptr <= w_last ? '0 : r_wptr + PW'(1);
    end
  end

  // Delivered-frame counter, free-running modulo 256.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= 8'd0;
    end else if (w_out_xfer) begin
      r_count <= r_count + 8'd1;
    end
  end

  sample_bank #(.N(N), .W(W)) u_bank0 (
    .clk     (clk),
    .i_we    (w_in_xfer & ~r_bsel),
    .i_waddr (r_wptr),
    .i_wdata (w_samp),
    .o_rdata (w_bank0_rd)
  );

  sample_bank #(.N(N), .W(W)) u_bank1 (
    .clk     (clk),
    .i_we    (w_in_xfer & r_bsel),
    .i_waddr (r_wptr),
    .i_wdata (w_samp),
    .o_rdata (w_bank1_rd)
  );

  // The read bank is always the one not being written.
  assign bus.frame_data  = r_bsel ? w_bank0_rd : w_bank1_rd;
  assign bus.frame_valid = r_frame_valid;
  assign bus.in_ready    = r_in_ready;
  assign bus.frame_count = r_count;

endmodule

// File: tb/tb_sample_framer.sv
// Scoreboard bench for sample_framer: accepted samples queue their expected
// converted value; a negedge monitor pops N of them at every frame handshake.
// Directed phases cover reset, stall, simultaneous swap, async reset and wrap.
module tb_sample_framer;

  localparam int N     = 16;
  localparam int ADC_W = 12;
  localparam int W     = 16;
  localparam int FW    = N * W;

  logic clk;
  logic rst;

  sample_framer_if #(.N(N), .ADC_W(ADC_W), .W(W)) bus ();

  sample_framer #(.N(N), .ADC_W(ADC_W), .W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int            n_chk;
  int            n_err;
  int            n_frames;
  logic [7:0]    mon_cnt;
  logic [W-1:0]  exp_q[$];
  logic          pend_prev;
  logic [FW-1:0] prev_data;

  task automatic chk(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference conversion: flip the offset-binary MSB, left-justify in 16 bits.
  function automatic logic [W-1:0] conv(input logic [ADC_W-1:0] d);
    logic [ADC_W-1:0] o;
    o = d ^ 12'h800;
    return {o, 4'h0};
  endfunction

  function automatic logic [W-1:0] samp(input int k);
    return bus.frame_data[k*W +: W];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one sample; queue its expected value at the edge that accepts it.
  task automatic send(input logic [ADC_W-1:0] d);
    int t;
    t = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    while (!bus.in_ready && t < 200) begin
      tick();
      t++;
    end
    if (!bus.in_ready) begin
      n_chk++;
      n_err++;
      $display("FAIL send_timeout: in_ready stayed %0b, required 1", bus.in_ready);
    end else begin
      exp_q.push_back(conv(d));
      tick();
    end
    bus.in_valid = 1'b0;
  endtask

  // Monitor: frame content and count at each handshake, stability while held.
  always @(negedge clk) begin
    if (rst) begin
      pend_prev = 1'b0;
    end else begin
      if (pend_prev && bus.frame_valid)
        chk("frame_stable", bus.frame_data, prev_data);
      if (bus.frame_valid && bus.frame_ready) begin
        if (exp_q.size() < N) begin
          n_chk++;
          n_err++;
          $display("FAIL frame_underflow: queued %0d samples, required %0d", exp_q.size(), N);
        end else begin
          logic [FW-1:0] ev;
          for (int k = 0; k < N; k++) ev[k*W +: W] = exp_q.pop_front();
          chk("frame_data", bus.frame_data, ev);
        end
        chk("frame_count_at_hs", FW'(bus.frame_count), FW'(mon_cnt));
        mon_cnt = mon_cnt + 8'd1;
        n_frames++;
      end
      pend_prev = bus.frame_valid && !bus.frame_ready;
      prev_data = bus.frame_data;
    end
  end

  initial begin
    int target;
    n_chk = 0; n_err = 0; n_frames = 0; mon_cnt = 8'd0;
    pend_prev = 1'b0; prev_data = '0;
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.frame_ready = 1'b0;

    // Reset state.
    repeat (3) tick();
    chk("rst_in_ready", FW'(bus.in_ready), FW'(0));
    chk("rst_frame_valid", FW'(bus.frame_valid), FW'(0));
    chk("rst_frame_count", FW'(bus.frame_count), FW'(0));
    rst = 1'b0;
    chk("in_ready_before_edge", FW'(bus.in_ready), FW'(0));
    tick();
    chk("in_ready_after_edge", FW'(bus.in_ready), FW'(1));

    // First frame: 0x000..0xF00, consumer always ready.
    bus.frame_ready = 1'b1;
    for (int i = 0; i < N; i++) send(12'(i * 256));
    chk("f1_valid", FW'(bus.frame_valid), FW'(1));
    chk("f1_s0", FW'(samp(0)), FW'(16'h8000));
    chk("f1_s15", FW'(samp(15)), FW'(16'h7000));
    tick();
    chk("f1_count", FW'(bus.frame_count), FW'(1));
    chk("f1_valid_drop", FW'(bus.frame_valid), FW'(0));

    // Stall: 32 samples with no consumer.
    bus.frame_ready = 1'b0;
    for (int i = 0; i < 2*N; i++) send(12'(i * 128));
    chk("stall_in_ready", FW'(bus.in_ready), FW'(0));
    chk("stall_valid", FW'(bus.frame_valid), FW'(1));
    chk("stall_s0", FW'(samp(0)), FW'(16'h8000));
    repeat (3) tick();
    chk("stall_in_ready_held", FW'(bus.in_ready), FW'(0));
    bus.frame_ready = 1'b1;
    tick();
    bus.frame_ready = 1'b0;
    chk("unstall_in_ready", FW'(bus.in_ready), FW'(1));
    chk("unstall_valid", FW'(bus.frame_valid), FW'(1));
    chk("unstall_s0", FW'(samp(0)), FW'(16'h0000));
    chk("unstall_s15", FW'(samp(15)), FW'(16'h7800));
    bus.frame_ready = 1'b1;
    tick();
    bus.frame_ready = 1'b0;
    chk("drain_valid", FW'(bus.frame_valid), FW'(0));
    chk("drain_count", FW'(bus.frame_count), FW'(3));

    // Simultaneous frame handshake and Nth-sample completion in PEND.
    for (int i = 0; i < N; i++) send(12'(12'h100 + i));
    for (int i = 0; i < N-1; i++) send(12'(12'h400 + i * 16));
    bus.frame_ready = 1'b1;
    send(12'hFFF);
    bus.frame_ready = 1'b0;
    chk("swap_valid", FW'(bus.frame_valid), FW'(1));
    chk("swap_in_ready", FW'(bus.in_ready), FW'(1));
    chk("swap_s0", FW'(samp(0)), FW'(16'hC000));
    chk("swap_s15", FW'(samp(15)), FW'(16'h7FF0));
    chk("swap_count", FW'(bus.frame_count), FW'(4));
    bus.frame_ready = 1'b1;
    tick();
    bus.frame_ready = 1'b0;
    chk("swap_drain_count", FW'(bus.frame_count), FW'(5));

    // Async reset with a pending frame and 9 samples of a partial one.
    for (int i = 0; i < N + 9; i++) send(12'(12'h0A0 + i));
    #3 rst = 1'b1;
    #1;
    chk("arst_valid", FW'(bus.frame_valid), FW'(0));
    chk("arst_in_ready", FW'(bus.in_ready), FW'(0));
    chk("arst_count", FW'(bus.frame_count), FW'(0));
    exp_q.delete();
    mon_cnt = 8'd0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    bus.frame_ready = 1'b1;
    for (int i = 0; i < N; i++) send(12'(12'h300 + i));
    chk("post_rst_s0", FW'(samp(0)), FW'(16'hB000));
    chk("post_rst_s15", FW'(samp(15)), FW'(16'hB0F0));
    tick();
    chk("post_rst_count", FW'(bus.frame_count), FW'(1));
    bus.frame_ready = 1'b0;

    // 256 more frames with random gaps on both sides; count wraps 257 -> 1.
    target = n_frames + 256;
    fork
      begin
        for (int i = 0; i < 256 * N; i++) begin
          repeat ($urandom_range(0, 2)) tick();
          send(12'($urandom));
        end
      end
      begin
        int cyc;
        cyc = 0;
        while (n_frames < target && cyc < 40000) begin
          bus.frame_ready = 1'($urandom_range(0, 1));
          tick();
          cyc++;
        end
        bus.frame_ready = 1'b0;
        if (n_frames < target) begin
          n_chk++;
          n_err++;
          $display("FAIL rand_frames_timeout: delivered %0d, required %0d", n_frames, target);
        end
      end
    join
    tick();
    chk("wrap_count", FW'(bus.frame_count), FW'(1));
    chk("wrap_queue_empty", FW'(exp_q.size()), FW'(0));
    chk("wrap_valid", FW'(bus.frame_valid), FW'(0));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
